// File: rtl/gh_pkg.sv
// Shared constants for the scoring slice: BCD converter state encoding,
// display digit count, rock-meter constants and the double-dabble digit adjust.
package gh_pkg;

  localparam int unsigned BCD_DIGITS = 6;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  localparam logic [1:0] BCD_IDLE  = 2'd0;
  localparam logic [1:0] BCD_SHIFT = 2'd1;
  localparam logic [1:0] BCD_DONE  = 2'd2;

  localparam int unsigned METER_W    = 7;
  localparam int unsigned METER_INIT = 50;
  localparam int unsigned METER_MAX  = 100;
  localparam int unsigned METER_HIT  = 2;
  localparam int unsigned METER_MISS = 8;

  // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Control inputs and score status bundle between the game core and score_keeper.
// With ROCK_METER_EN defined, the bundle also carries rock_meter and game_over.
interface score_keeper_if
  import gh_pkg::*;
#(
  parameter int unsigned SCORE_W  = 20,
  parameter int unsigned STREAK_W = 10
);

  logic                pause;
  logic                stop;
  logic                note_hit;
  logic                note_miss;
  logic [SCORE_W-1:0]  score;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] best_streak;
  logic [2:0]          multiplier;
  logic [BCD_W-1:0]    score_bcd;
  logic                bcd_valid;
`ifdef ROCK_METER_EN
  logic [METER_W-1:0]  rock_meter;
  logic                game_over;

  modport master (
    output pause, stop, note_hit, note_miss,
    input  score, streak, best_streak, multiplier, score_bcd, bcd_valid,
    input  rock_meter, game_over
  );

  modport slave (
    input  pause, stop, note_hit, note_miss,
    output score, streak, best_streak, multiplier, score_bcd, bcd_valid,
    output rock_meter, game_over
  );
`else
  modport master (
    output pause, stop, note_hit, note_miss,
    input  score, streak, best_streak, multiplier, score_bcd, bcd_valid
  );

  modport slave (
    input  pause, stop, note_hit, note_miss,
    output score, streak, best_streak, multiplier, score_bcd, bcd_valid
  );
`endif

endinterface

// File: rtl/score_bin2bcd.sv
// Sequential double-dabble: IDLE -> SHIFT (SCORE_W cycles) -> DONE -> IDLE.
// start is accepted in IDLE and in DONE (back-to-back restart); abort returns to IDLE.
module score_bin2bcd
  import gh_pkg::*;
#(
  parameter int unsigned SCORE_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               abort,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic [BCD_W-1:0]   bcd,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_W = $clog2(SCORE_W);

  logic [1:0]         state, state_nxt;
  logic [SCORE_W-1:0] sh_bin, sh_bin_nxt;
  logic [BCD_W-1:0]   bcd_nxt, bcd_adj;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               busy_nxt, done_nxt;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state  <= BCD_IDLE;
      sh_bin <= '0;
      bcd    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      sh_bin <= sh_bin_nxt;
      bcd    <= bcd_nxt;
      cnt    <= cnt_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  // Next state, shift step and registered status flags.
  always_comb begin
    state_nxt  = state;
    sh_bin_nxt = sh_bin;
    bcd_nxt    = bcd;
    cnt_nxt    = cnt;
    bcd_adj    = dd_adjust(bcd);
    case (state)
      BCD_IDLE: begin
        if (start) begin
          sh_bin_nxt = bin;
          bcd_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = BCD_SHIFT;
        end
      end
      BCD_SHIFT: begin
        bcd_nxt    = {bcd_adj[BCD_W-2:0], sh_bin[SCORE_W-1]};
        sh_bin_nxt = sh_bin << 1;
        cnt_nxt    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(SCORE_W - 1)) state_nxt = BCD_DONE;
      end
      BCD_DONE: begin
        if (start) begin
          sh_bin_nxt = bin;
          bcd_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = BCD_SHIFT;
        end else begin
          state_nxt  = BCD_IDLE;
        end
      end
      default: state_nxt = BCD_IDLE;
    endcase
    busy_nxt = (state_nxt != BCD_IDLE);
    done_nxt = (state_nxt == BCD_DONE);
  end

endmodule

// File: rtl/score_keeper.sv
// Scoring stage: score, streak, best streak, multiplier and a BCD image of the score.
// Optional feature macro: ROCK_METER_EN adds rock_meter / game_over with scoring lockout.
module score_keeper
  import gh_pkg::*;
#(
  parameter int unsigned SCORE_W     = 20,
  parameter int unsigned SCORE_MAX   = 999999,
  parameter int unsigned STREAK_W    = 10,
  parameter int unsigned BASE_PTS    = 50,
  parameter int unsigned STREAK_STEP = 10,
  parameter int unsigned MAX_MULT    = 4
) (
  input  logic           clk,
  input  logic           reset,
  score_keeper_if.slave  sk
);

  logic [SCORE_W-1:0]  score_q, score_nxt;
  logic [SCORE_W:0]    sum_c;
  logic [STREAK_W-1:0] streak_q, streak_nxt, best_q, best_nxt, step_cnt_c;
  logic [2:0]          mult_q, mult_nxt;
  logic [BCD_W-1:0]    score_bcd_q, conv_bcd;
  logic                bcd_valid_q, pending_q;
  logic                conv_busy, conv_done;
  logic                hit_c, miss_c, lock_c, score_chg_c, conv_start_c;

`ifdef ROCK_METER_EN
  logic [METER_W-1:0]  meter_q, meter_nxt;
  logic                game_over_q, game_over_nxt;

  assign lock_c = game_over_q;
`else
  assign lock_c = 1'b0;
`endif

  // Pause and game-over drop pulses; a simultaneous hit and miss counts as a miss.
  assign miss_c = sk.note_miss & ~sk.pause & ~lock_c;
  assign hit_c  = sk.note_hit & ~sk.note_miss & ~sk.pause & ~lock_c;

  // Next score, streak, best streak and multiplier (multiplier follows the new streak).
  always_comb begin
    score_nxt  = score_q;
    streak_nxt = streak_q;
    best_nxt   = best_q;
    sum_c      = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(BASE_PTS * 32'(mult_q));
    if (miss_c) begin
      streak_nxt = '0;
    end else if (hit_c) begin
      score_nxt  = (sum_c > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum_c[SCORE_W-1:0];
      streak_nxt = (&streak_q) ? streak_q : streak_q + STREAK_W'(1);
      if (streak_nxt > best_q) best_nxt = streak_nxt;
    end
    step_cnt_c = streak_nxt / STREAK_W'(STREAK_STEP);
    if (step_cnt_c >= STREAK_W'(MAX_MULT - 1)) mult_nxt = 3'(MAX_MULT);
    else                                        mult_nxt = 3'(step_cnt_c) + 3'd1;
  end

`ifdef ROCK_METER_EN
  // Rock meter: miss drains (game over at 0), hit refills up to the ceiling.
  always_comb begin
    meter_nxt     = meter_q;
    game_over_nxt = game_over_q;
    if (miss_c) begin
      meter_nxt = (meter_q <= METER_W'(METER_MISS)) ? '0 : meter_q - METER_W'(METER_MISS);
      if (meter_nxt == '0) game_over_nxt = 1'b1;
    end else if (hit_c) begin
      meter_nxt = (meter_q >= METER_W'(METER_MAX - METER_HIT)) ? METER_W'(METER_MAX)
                                                              : meter_q + METER_W'(METER_HIT);
    end
  end
`endif

  // Start a conversion on a change when idle or finishing, or replay a pending change.
  assign score_chg_c  = (score_nxt != score_q);
  assign conv_start_c = (score_chg_c && (!conv_busy || conv_done)) || (conv_done && pending_q);

  score_bin2bcd #(.SCORE_W(SCORE_W)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .abort (sk.stop),
    .start (conv_start_c),
    .bin   (score_nxt),
    .bcd   (conv_bcd),
    .busy  (conv_busy),
    .done  (conv_done)
  );

  // State registers: reset > stop > normal update.
  always_ff @(posedge clk) begin
    if (reset || sk.stop) begin
      score_q     <= '0;
      streak_q    <= '0;
      mult_q      <= 3'd1;
      score_bcd_q <= '0;
      bcd_valid_q <= 1'b1;
      pending_q   <= 1'b0;
      if (reset) best_q <= '0;
`ifdef ROCK_METER_EN
      meter_q     <= METER_W'(METER_INIT);
      game_over_q <= 1'b0;
`endif
    end else begin
      score_q  <= score_nxt;
      streak_q <= streak_nxt;
      best_q   <= best_nxt;
      mult_q   <= mult_nxt;
`ifdef ROCK_METER_EN
      meter_q     <= meter_nxt;
      game_over_q <= game_over_nxt;
`endif
      if (conv_start_c)                  pending_q <= 1'b0;
      else if (score_chg_c && conv_busy) pending_q <= 1'b1;
      if (score_chg_c) begin
        bcd_valid_q <= 1'b0;
      end else if (conv_done && !pending_q) begin
        score_bcd_q <= conv_bcd;
        bcd_valid_q <= 1'b1;
      end
    end
  end

  assign sk.score       = score_q;
  assign sk.streak      = streak_q;
  assign sk.best_streak = best_q;
  assign sk.multiplier  = mult_q;
  assign sk.score_bcd   = score_bcd_q;
  assign sk.bcd_valid   = bcd_valid_q;
`ifdef ROCK_METER_EN
  assign sk.rock_meter  = meter_q;
  assign sk.game_over   = game_over_q;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper; rock-meter cases run when ROCK_METER_EN is defined.
module tb_score_keeper;
  import gh_pkg::*;

  localparam int unsigned SCORE_W  = 20;
  localparam int unsigned STREAK_W = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  score_keeper_if #(.SCORE_W(SCORE_W), .STREAK_W(STREAK_W)) sk();

  score_keeper u_dut (
    .clk   (clk),
    .reset (reset),
    .sk    (sk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hits(input int n);
    sk.note_hit = 1'b1;
    repeat (n) @(negedge clk);
    sk.note_hit = 1'b0;
  endtask

  task automatic misses(input int n);
    sk.note_miss = 1'b1;
    repeat (n) @(negedge clk);
    sk.note_miss = 1'b0;
  endtask

  task automatic do_stop();
    sk.stop = 1'b1;
    @(negedge clk);
    sk.stop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic wait_bcd(input string tag, input int budget);
    int k;
    k = 0;
    while (!sk.bcd_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(sk.bcd_valid), 32'd1);
  endtask

  initial begin
    reset        = 1'b1;
    sk.pause     = 1'b0;
    sk.stop      = 1'b0;
    sk.note_hit  = 1'b0;
    sk.note_miss = 1'b0;
    idle(2);
    reset = 1'b0;

    // Reset state
    check("rst_score",  32'(sk.score),       32'd0);
    check("rst_streak", 32'(sk.streak),      32'd0);
    check("rst_best",   32'(sk.best_streak), 32'd0);
    check("rst_mult",   32'(sk.multiplier),  32'd1);
    check("rst_bcd",    32'(sk.score_bcd),   32'h0);
    check("rst_valid",  32'(sk.bcd_valid),   32'd1);

    // 1: three hits four cycles apart
    hits(1);
    check("t1_valid_drop", 32'(sk.bcd_valid), 32'd0);
    idle(3); hits(1); idle(3); hits(1);
    check("t1_score",  32'(sk.score),      32'd150);
    check("t1_streak", 32'(sk.streak),     32'd3);
    check("t1_mult",   32'(sk.multiplier), 32'd1);
    wait_bcd("t1_bcd_ready", 50);
    check("t1_bcd", 32'(sk.score_bcd), 32'h000150);
    // isolated conversion completes within SCORE_W+2 cycles
    idle(1); hits(1);
    wait_bcd("t1_lat_ready", 22);
    check("t1_lat_bcd", 32'(sk.score_bcd), 32'h000200);

    // 2: multiplier steps
    do_stop();
    hits(10);
    check("t2_score10", 32'(sk.score),      32'd500);
    check("t2_mult10",  32'(sk.multiplier), 32'd2);
    hits(1);
    check("t2_score11", 32'(sk.score),      32'd600);
    hits(28);
    check("t2_score39", 32'(sk.score),      32'd4800);
    check("t2_mult39",  32'(sk.multiplier), 32'd4);
    hits(1);
    check("t2_score40", 32'(sk.score),      32'd5000);
    hits(20);
    check("t2_score60",  32'(sk.score),      32'd9000);
    check("t2_mult60",   32'(sk.multiplier), 32'd4);
    check("t2_streak60", 32'(sk.streak),     32'd60);
    wait_bcd("t2_bcd_ready", 50);
    check("t2_bcd", 32'(sk.score_bcd), 32'h009000);

    // 3: miss and hit+miss
    do_reset();
    hits(25);
    check("t3_score25", 32'(sk.score),      32'd2250);
    check("t3_mult25",  32'(sk.multiplier), 32'd3);
    misses(1);
    check("t3_miss_streak", 32'(sk.streak),      32'd0);
    check("t3_miss_mult",   32'(sk.multiplier),  32'd1);
    check("t3_miss_best",   32'(sk.best_streak), 32'd25);
    check("t3_miss_score",  32'(sk.score),       32'd2250);
    hits(2);
    sk.note_hit = 1'b1; sk.note_miss = 1'b1;
    @(negedge clk);
    sk.note_hit = 1'b0; sk.note_miss = 1'b0;
    check("t3_both_streak", 32'(sk.streak), 32'd0);
    check("t3_both_score",  32'(sk.score),  32'd2350);

    // 4: pause and stop
    sk.pause = 1'b1;
    hits(5);
    sk.pause = 1'b0;
    check("t4_pause_score",  32'(sk.score),  32'd2350);
    check("t4_pause_streak", 32'(sk.streak), 32'd0);
    hits(1);
    check("t4_unpause_score", 32'(sk.score), 32'd2400);
    sk.pause = 1'b1;
    wait_bcd("t4_paused_bcd_ready", 50);
    check("t4_paused_bcd", 32'(sk.score_bcd), 32'h002400);
    sk.pause = 1'b0;
    hits(1); idle(5);
    check("t4_mid_conv", 32'(sk.bcd_valid), 32'd0);
    do_stop();
    check("t4_stop_score",  32'(sk.score),       32'd0);
    check("t4_stop_bcd",    32'(sk.score_bcd),   32'h0);
    check("t4_stop_valid",  32'(sk.bcd_valid),   32'd1);
    check("t4_stop_best",   32'(sk.best_streak), 32'd25);
    check("t4_stop_mult",   32'(sk.multiplier),  32'd1);
    sk.stop = 1'b1;
    hits(3);
    sk.stop = 1'b0;
    check("t4_held_score",  32'(sk.score),  32'd0);
    check("t4_held_streak", 32'(sk.streak), 32'd0);
    idle(1);
    check("t4_held_valid", 32'(sk.bcd_valid), 32'd1);

    // 5: saturation of score and streak, back-to-back conversions
    hits(3); misses(1); hits(30);
    check("t5_score_base", 32'(sk.score),      32'd3150);
    check("t5_mult_base",  32'(sk.multiplier), 32'd4);
    hits(4984);
    check("t5_score_near", 32'(sk.score),       32'd999950);
    check("t5_streak_sat", 32'(sk.streak),      32'd1023);
    check("t5_best_sat",   32'(sk.best_streak), 32'd1023);
    hits(1);
    check("t5_score_sat", 32'(sk.score), 32'd999999);
    wait_bcd("t5_bcd_ready", 50);
    check("t5_bcd", 32'(sk.score_bcd), 32'h999999);
    hits(2);
    check("t5_score_hold", 32'(sk.score),     32'd999999);
    check("t5_valid_hold", 32'(sk.bcd_valid), 32'd1);

`ifdef ROCK_METER_EN
    // 6: rock meter drain, lockout and recovery
    do_reset();
    check("t6_meter_init", 32'(sk.rock_meter), 32'd50);
    misses(6);
    check("t6_meter6", 32'(sk.rock_meter), 32'd2);
    check("t6_go6",    32'(sk.game_over),  32'd0);
    misses(1);
    check("t6_meter7", 32'(sk.rock_meter), 32'd0);
    check("t6_go7",    32'(sk.game_over),  32'd1);
    hits(3);
    check("t6_locked_score", 32'(sk.score),      32'd0);
    check("t6_locked_meter", 32'(sk.rock_meter), 32'd0);
    do_stop();
    check("t6_stop_meter", 32'(sk.rock_meter), 32'd50);
    check("t6_stop_go",    32'(sk.game_over),  32'd0);
    hits(1);
    check("t6_resume_score", 32'(sk.score),      32'd50);
    check("t6_resume_meter", 32'(sk.rock_meter), 32'd52);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
